branch_redirect_ctrl: RTL and testbench
=======================================

# branch_redirect_ctrl

Sequential branch-resolution controller for the RV32 pipeline. Takes a resolved branch or jump from EX, decides taken/not-taken from the 10-bit combined funct3/opcode and the ALU Z/N flags, and drives the PC redirect. It then squashes wrong-path instructions for a programmable number of cycles, honouring pipeline stall. It sits between the EX-stage ALU flags and the IF-stage PC mux / pipeline-register flush inputs.

## Interface
- SQUASH_CYCLES, 2: cycles `flush_ifid` stays high after a taken redirect; legal range 1–15.
- ADDR_W, 32: PC/target width.
- clk  in  1  pipeline clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high; the only reset.
- br_valid  in  1  EX holds a conditional branch this cycle.
- jump_valid  in  1  EX holds JAL/JALR (unconditionally taken); has priority over br_valid.
- comb_opfunct  in  10  {funct3, opcode} of the EX instruction.
- z, n  in  1 each  ALU zero / negative (or unsigned-less-than for U ops) flags.
- br_target  in  ADDR_W  computed target address.
- stall  in  1  pipeline hold from the hazard unit.
- pc_sel  out  1  PC mux selects `pc_target`.
- pc_target  out  ADDR_W  registered redirect address.
- flush_ifid  out  1  clear IF/ID register.
- flush_idex  out  1  clear ID/EX register.
- busy  out  1  controller is not IDLE.

## Operation
- Taken rules. All other codes are not-taken.
  - BEQ 0001100011: z=1.
  - BNE 0011100011: z=0.
  - BLT 1001100011: n=1.
  - BGE 1011100011: z=1 or n=0.
  - BLTU 1101100011: n=1.
  - BGEU 1111100011: z=1 or n=0.
- FSM states IDLE, REDIRECT, SQUASH.
- IDLE:
  - Sampling: on a cycle with stall=0, sample jump_valid/br_valid. While stall=1, IDLE samples nothing.
  - Taken: capture br_target into pc_target, load squash counter with SQUASH_CYCLES-1, go to REDIRECT.
  - Not-taken or no request: stay in IDLE with all outputs 0.
- REDIRECT:
  - Outputs: pc_sel=1, flush_ifid=1, flush_idex=1, busy=1.
  - stall=1: hold state and outputs.
  - stall=0, counter=0: go to IDLE.
  - stall=0, counter≠0: go to SQUASH.
- SQUASH:
  - Outputs: flush_ifid=1, busy=1, pc_sel=0, flush_idex=0.
  - The counter decrements only on stall=0.
  - When counter=0 and stall=0, go to IDLE.
- While busy, br_valid and jump_valid are ignored because those instructions are wrong-path.
- pc_target holds its last value until the next capture.

## Timing
- Reset values: all outputs 0, pc_target 0, state IDLE, counter 0.
- Reset asserted mid-REDIRECT/SQUASH: at the next edge go to IDLE with outputs 0. The pending redirect is dropped.
- Latency: a request sampled at edge k gives pc_sel=1 in cycle k+1 (registered outputs; no combinational input→output path).
- flush_ifid is high for exactly SQUASH_CYCLES non-stalled cycles per taken branch. flush_idex and pc_sel are high for exactly 1 non-stalled cycle.
- Back-to-back: a new request can first be accepted on the edge that leaves for IDLE + 1. The cycle in which busy drops is IDLE and may accept.
- jump_valid and br_valid high together: treat as a jump, taken.

## Configuration
- BRANCH_STATS_EN defined:
  - Adds outputs br_count[31:0] (accepted conditional branches) and taken_count[31:0] (accepted taken branches plus jumps).
  - Both reset to 0, increment on acceptance in IDLE, and wrap at 2^32.
- Not defined: these ports and counters do not exist, and all other behaviour is identical.

## Structure
- Package branch_ctrl_pkg holds:
  - the six opfunct localparams (OPF_BEQ … OPF_BGEU);
  - the FSM state typedef (ST_IDLE, ST_REDIRECT, ST_SQUASH);
  - the squash counter width constant (4).
- Sub-module branch_cond_eval: purely combinational, mapping (comb_opfunct, z, n) to taken.
- Top level: FSM, counter, target register, optional stats.

## Test plan
- BEQ 0001100011, z=1, target 0x0000_0100, stall=0 → next cycle pc_sel=1, pc_target=0x100, both flushes high; flush_ifid high 2 cycles total; busy low on cycle 3.
- BNE with z=1 → no redirect; outputs stay 0; with BRANCH_STATS_EN, br_count=1, taken_count=0.
- JAL (jump_valid=1) and br_valid=1 with BNE not-taken together → redirect taken to br_target; br_valid with another target during SQUASH is ignored.
- Taken BGE (n=0), stall=1 for 3 cycles in REDIRECT → pc_sel/flush_idex held 3 cycles, then 1 more unstalled; flush_ifid total non-stalled count = SQUASH_CYCLES.
- reset pulse during SQUASH (SQUASH_CYCLES=4) → next cycle all outputs 0, state IDLE; a fresh BLT with n=1 is accepted immediately.
- Undefined opfunct 0101100011 with z=1, n=1 → never taken.

Source files
------------

// File: rtl/branch_ctrl_pkg.sv
// Shared constants and types for the branch redirect controller.
// Optional statistics counters are enabled with the BRANCH_STATS_EN macro.
package branch_ctrl_pkg;

   // Branch codes are {funct3, opcode}.
   localparam logic [9:0] OPF_BEQ  = 10'b000_1100011;
   localparam logic [9:0] OPF_BNE  = 10'b001_1100011;
   localparam logic [9:0] OPF_BLT  = 10'b100_1100011;
   localparam logic [9:0] OPF_BGE  = 10'b101_1100011;
   localparam logic [9:0] OPF_BLTU = 10'b110_1100011;
   localparam logic [9:0] OPF_BGEU = 10'b111_1100011;

   localparam int CNT_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REDIRECT,
      ST_SQUASH
   } state_t;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational taken/not-taken decision from the branch code and ALU flags.
module branch_cond_eval
   import branch_ctrl_pkg::*;
(
   input  logic [9:0] comb_opfunct,
   input  logic       z,
   input  logic       n,
   output logic       taken
);

   // n carries the unsigned-less-than flag for the U variants, so the
   // signed and unsigned pairs share the same rule.
   always_comb begin
      taken = 1'b0;
      case (comb_opfunct)
         OPF_BEQ:  taken = z;
         OPF_BNE:  taken = ~z;
         OPF_BLT:  taken = n;
         OPF_BGE:  taken = z | ~n;
         OPF_BLTU: taken = n;
         OPF_BGEU: taken = z | ~n;
         default:  taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Branch resolution FSM: PC redirect, wrong-path squash and optional stats.
// Define BRANCH_STATS_EN to add the br_count/taken_count outputs.
module branch_redirect_ctrl
   import branch_ctrl_pkg::*;
#(
   parameter int SQUASH_CYCLES = 2,
   parameter int ADDR_W        = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              br_valid,
   input  logic              jump_valid,
   input  logic [9:0]        comb_opfunct,
   input  logic              z,
   input  logic              n,
   input  logic [ADDR_W-1:0] br_target,
   input  logic              stall,
   output logic              pc_sel,
   output logic [ADDR_W-1:0] pc_target,
   output logic              flush_ifid,
   output logic              flush_idex,
   output logic              busy
`ifdef BRANCH_STATS_EN
   ,
   output logic [31:0]       br_count,
   output logic [31:0]       taken_count
`endif
);

   state_t            r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [ADDR_W-1:0] r_pcTarget;
   logic              r_pcSel;
   logic              r_flushIfid;
   logic              r_flushIdex;
   logic              r_busy;
   logic              w_condTaken;
   logic              w_accept;

   branch_cond_eval u_condEval (
      .comb_opfunct (comb_opfunct),
      .z            (z),
      .n            (n),
      .taken        (w_condTaken)
   );

   assign w_accept = jump_valid | (br_valid & w_condTaken);

   // REDIRECT counts as the first flush_ifid cycle, so the counter is
   // decremented on the way into SQUASH and SQUASH runs until it hits zero.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_pcTarget  <= '0;
         r_pcSel     <= 1'b0;
         r_flushIfid <= 1'b0;
         r_flushIdex <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (!stall && w_accept) begin
                  r_state     <= ST_REDIRECT;
                  r_cnt       <= CNT_W'(SQUASH_CYCLES - 1);
                  r_pcTarget  <= br_target;
                  r_pcSel     <= 1'b1;
                  r_flushIfid <= 1'b1;
                  r_flushIdex <= 1'b1;
                  r_busy      <= 1'b1;
               end
            end
            ST_REDIRECT: begin
               if (!stall) begin
                  r_pcSel     <= 1'b0;
                  r_flushIdex <= 1'b0;
                  if (r_cnt == '0) begin
                     r_state     <= ST_IDLE;
                     r_flushIfid <= 1'b0;
                     r_busy      <= 1'b0;
                  end else begin
                     r_state <= ST_SQUASH;
                     r_cnt   <= r_cnt - 1'b1;
                  end
               end
            end
            ST_SQUASH: begin
               if (!stall) begin
                  if (r_cnt == '0) begin
                     r_state     <= ST_IDLE;
                     r_flushIfid <= 1'b0;
                     r_busy      <= 1'b0;
                  end else begin
                     r_cnt <= r_cnt - 1'b1;
                  end
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               r_pcSel     <= 1'b0;
               r_flushIfid <= 1'b0;
               r_flushIdex <= 1'b0;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

   assign pc_sel     = r_pcSel;
   assign pc_target  = r_pcTarget;
   assign flush_ifid = r_flushIfid;
   assign flush_idex = r_flushIdex;
   assign busy       = r_busy;

`ifdef BRANCH_STATS_EN
   logic [31:0] r_brCount;
   logic [31:0] r_takenCount;

   // A jump wins over a simultaneous branch, so only lone branches count
   // toward br_count.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_brCount    <= '0;
         r_takenCount <= '0;
      end else if (r_state == ST_IDLE && !stall) begin
         if (jump_valid) begin
            r_takenCount <= r_takenCount + 32'd1;
         end else if (br_valid) begin
            r_brCount <= r_brCount + 32'd1;
            if (w_condTaken) begin
               r_takenCount <= r_takenCount + 32'd1;
            end
         end
      end
   end

   assign br_count    = r_brCount;
   assign taken_count = r_takenCount;
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed scoreboard bench for branch_redirect_ctrl (SQUASH_CYCLES=2).
module tb_branch_redirect_ctrl;

   localparam int ADDR_W = 32;

   localparam logic [9:0] BEQ  = 10'b000_1100011;
   localparam logic [9:0] BNE  = 10'b001_1100011;
   localparam logic [9:0] BLT  = 10'b100_1100011;
   localparam logic [9:0] BGE  = 10'b101_1100011;
   localparam logic [9:0] BLTU = 10'b110_1100011;
   localparam logic [9:0] BGEU = 10'b111_1100011;
   localparam logic [9:0] UNDF = 10'b010_1100011;

   typedef struct {
      logic        pcSel;
      logic [31:0] pcTarget;
      logic        flushIfid;
      logic        flushIdex;
      logic        busy;
      int          step;
   } exp_t;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              brValid = 1'b0;
   logic              jumpValid = 1'b0;
   logic [9:0]        opf = '0;
   logic              zFlag = 1'b0;
   logic              nFlag = 1'b0;
   logic [ADDR_W-1:0] target = '0;
   logic              stall = 1'b0;
   logic              pcSel;
   logic [ADDR_W-1:0] pcTarget;
   logic              flushIfid;
   logic              flushIdex;
   logic              busy;
`ifdef BRANCH_STATS_EN
   logic [31:0]       brCount;
   logic [31:0]       takenCount;
`endif

   exp_t expQ[$];
   int   total = 0;
   int   bad = 0;
   int   stepNum = 0;

   always #5 clk = ~clk;

   branch_redirect_ctrl #(.SQUASH_CYCLES(2), .ADDR_W(ADDR_W)) dut (
      .clk          (clk),
      .reset        (reset),
      .br_valid     (brValid),
      .jump_valid   (jumpValid),
      .comb_opfunct (opf),
      .z            (zFlag),
      .n            (nFlag),
      .br_target    (target),
      .stall        (stall),
      .pc_sel       (pcSel),
      .pc_target    (pcTarget),
      .flush_ifid   (flushIfid),
      .flush_idex   (flushIdex),
      .busy         (busy)
`ifdef BRANCH_STATS_EN
      ,
      .br_count     (brCount),
      .taken_count  (takenCount)
`endif
   );

   task automatic checkOutput(input string name, input int step,
                              input logic [31:0] actual, input logic [31:0] required);
      total++;
      if (actual !== required) begin
         bad++;
         $display("[TB] FAIL %s step %0d: got 0x%0h, expected 0x%0h", name, step, actual, required);
      end
   endtask

   // Drives one cycle of inputs and queues what the outputs must be after
   // the next rising edge.
   task automatic applyStimulus(input logic rst, input logic jv, input logic bv,
                                input logic [9:0] code, input logic zz, input logic nn,
                                input logic [31:0] tgt, input logic stl,
                                input logic ePs, input logic [31:0] eTgt,
                                input logic eFi, input logic eFx, input logic eBz);
      exp_t e;
      @(posedge clk);
      #2;
      reset     = rst;
      jumpValid = jv;
      brValid   = bv;
      opf       = code;
      zFlag     = zz;
      nFlag     = nn;
      target    = tgt;
      stall     = stl;
      stepNum++;
      e.pcSel     = ePs;
      e.pcTarget  = eTgt;
      e.flushIfid = eFi;
      e.flushIdex = eFx;
      e.busy      = eBz;
      e.step      = stepNum;
      expQ.push_back(e);
   endtask

   // Monitor: the DUT presents a registered output every cycle, checked
   // just after the edge against the oldest queued expectation.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("pc_sel",     e.step, 32'(pcSel),     32'(e.pcSel));
            checkOutput("pc_target",  e.step, pcTarget,       e.pcTarget);
            checkOutput("flush_ifid", e.step, 32'(flushIfid), 32'(e.flushIfid));
            checkOutput("flush_idex", e.step, 32'(flushIdex), 32'(e.flushIdex));
            checkOutput("busy",       e.step, 32'(busy),      32'(e.busy));
         end
      end
   end

   initial begin
      //             rst jv bv code  z  n  target      stl  ps tgt         fi fx bz
      applyStimulus(1, 0, 0, '0,   0, 0, 32'h0,     0,   0, 32'h0,     0, 0, 0);
      applyStimulus(1, 0, 0, '0,   0, 0, 32'h0,     0,   0, 32'h0,     0, 0, 0);
      applyStimulus(0, 0, 0, '0,   0, 0, 32'h0,     0,   0, 32'h0,     0, 0, 0);
      // Taken BEQ: one REDIRECT cycle, one SQUASH cycle, then idle.
      applyStimulus(0, 0, 1, BEQ,  1, 0, 32'h100,   0,   1, 32'h100,   1, 1, 1);
      applyStimulus(0, 0, 0, '0,   0, 0, 32'h0,     0,   0, 32'h100,   1, 0, 1);
      applyStimulus(0, 0, 0, '0,   0, 0, 32'h0,     0,   0, 32'h100,   0, 0, 0);
      applyStimulus(0, 0, 1, BNE,  1, 0, 32'h200,   0,   0, 32'h100,   0, 0, 0);
      // Jump with a not-taken BNE alongside; later branches are wrong-path.
      applyStimulus(0, 1, 1, BNE,  1, 0, 32'h300,   0,   1, 32'h300,   1, 1, 1);
      applyStimulus(0, 0, 1, BEQ,  1, 0, 32'h400,   0,   0, 32'h300,   1, 0, 1);
      applyStimulus(0, 0, 1, BEQ,  1, 0, 32'h400,   0,   0, 32'h300,   0, 0, 0);
      // Taken BGE held three cycles in REDIRECT, then a stall in SQUASH.
      applyStimulus(0, 0, 1, BGE,  0, 0, 32'h500,   0,   1, 32'h500,   1, 1, 1);
      applyStimulus(0, 0, 0, '0,   0, 0, 32'h0,     1,   1, 32'h500,   1, 1, 1);
      applyStimulus(0, 0, 0, '0,   0, 0, 32'h0,     1,   1, 32'h500,   1, 1, 1);
      applyStimulus(0, 0, 0, '0,   0, 0, 32'h0,     1,   1, 32'h500,   1, 1, 1);
      applyStimulus(0, 0, 0, '0,   0, 0, 32'h0,     0,   0, 32'h500,   1, 0, 1);
      applyStimulus(0, 0, 0, '0,   0, 0, 32'h0,     1,   0, 32'h500,   1, 0, 1);
      applyStimulus(0, 0, 0, '0,   0, 0, 32'h0,     0,   0, 32'h500,   0, 0, 0);
      applyStimulus(0, 0, 1, BEQ,  1, 0, 32'h600,   1,   0, 32'h500,   0, 0, 0);
      // Reset in SQUASH drops everything; a new BLT is taken right away.
      applyStimulus(0, 0, 1, BLTU, 0, 1, 32'h700,   0,   1, 32'h700,   1, 1, 1);
      applyStimulus(0, 0, 0, '0,   0, 0, 32'h0,     0,   0, 32'h700,   1, 0, 1);
      applyStimulus(1, 0, 1, BLT,  0, 1, 32'h800,   0,   0, 32'h0,     0, 0, 0);
      applyStimulus(0, 0, 1, BLT,  0, 1, 32'h800,   0,   1, 32'h800,   1, 1, 1);
      applyStimulus(0, 0, 1, BEQ,  1, 0, 32'h900,   0,   0, 32'h800,   1, 0, 1);
      applyStimulus(0, 0, 1, BGEU, 1, 1, 32'hA00,   0,   0, 32'h800,   0, 0, 0);
      // The cycle busy drops is IDLE and accepts the next branch.
      applyStimulus(0, 0, 1, BGEU, 0, 0, 32'hA00,   0,   1, 32'hA00,   1, 1, 1);
      applyStimulus(0, 0, 0, '0,   0, 0, 32'h0,     0,   0, 32'hA00,   1, 0, 1);
      applyStimulus(0, 0, 0, '0,   0, 0, 32'h0,     0,   0, 32'hA00,   0, 0, 0);
      applyStimulus(0, 0, 1, UNDF, 1, 1, 32'hB00,   0,   0, 32'hA00,   0, 0, 0);
      applyStimulus(0, 0, 1, BLT,  0, 0, 32'hB00,   0,   0, 32'hA00,   0, 0, 0);
      applyStimulus(0, 0, 1, BGE,  0, 1, 32'hB00,   0,   0, 32'hA00,   0, 0, 0);
      applyStimulus(0, 0, 1, BGEU, 0, 1, 32'hB00,   0,   0, 32'hA00,   0, 0, 0);
      applyStimulus(0, 0, 1, BNE,  0, 1, 32'hC00,   0,   1, 32'hC00,   1, 1, 1);
      applyStimulus(0, 0, 0, '0,   0, 0, 32'h0,     0,   0, 32'hC00,   1, 0, 1);
      applyStimulus(0, 0, 0, '0,   0, 0, 32'h0,     0,   0, 32'hC00,   0, 0, 0);

      for (int i = 0; i < 10 && expQ.size() > 0; i++) begin
         @(posedge clk);
         #2;
      end
      if (expQ.size() > 0) begin
         total++;
         bad++;
         $display("[TB] FAIL drain: %0d expectations left, expected 0", expQ.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
